// File: rtl/pixel_canvas.sv
// 28x28 one-bit drawing canvas with a step-driven cursor, a square pen/erase brush,
// a row-sweep clear FSM and a zero-latency read port for the classifier scan.
module pixel_canvas #(
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int ADDR_W    = 10,
  parameter int BRUSH     = 1,
  parameter int CURSOR_X0 = 14,
  parameter int CURSOR_Y0 = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mv_up,
  input  logic              mv_down,
  input  logic              mv_left,
  input  logic              mv_right,
  input  logic              pen_down,
  input  logic              erase,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              read_data,
  output logic [4:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              cursor_pix,
  output logic              busy
);

  localparam int NPIX = COLS * ROWS;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        row_cnt_q, row_cnt_d;
  logic [4:0]        cursor_x_q, cursor_x_d;
  logic [4:0]        cursor_y_q, cursor_y_d;
  logic [NPIX-1:0]   pix_q, pix_d;

  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] row_base;
  logic              draw_en;
  logic              wr_val;
  logic              right_ok;
  logic              down_ok;

  // Opposing pulses in the same cycle cancel; each axis saturates at its edges.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    if (mv_left && !mv_right && cursor_x_q != 5'd0)
      cursor_x_d = cursor_x_q - 5'd1;
    else if (mv_right && !mv_left && cursor_x_q != 5'(COLS - 1))
      cursor_x_d = cursor_x_q + 5'd1;
    if (mv_up && !mv_down && cursor_y_q != 5'd0)
      cursor_y_d = cursor_y_q - 5'd1;
    else if (mv_down && !mv_up && cursor_y_q != 5'(ROWS - 1))
      cursor_y_d = cursor_y_q + 5'd1;
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    busy      = (state_q == ST_CLEAR);
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          row_cnt_d = 5'd0;
        end
      end
      ST_CLEAR: begin
        if (row_cnt_q == 5'(ROWS - 1)) state_d = ST_IDLE;
        else                           row_cnt_d = row_cnt_q + 5'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Brush targets use the pre-move cursor; a clear request wins over a same-cycle draw.
  always_comb begin
    cur_idx  = ADDR_W'(cursor_y_q) * ADDR_W'(COLS) + ADDR_W'(cursor_x_q);
    row_base = ADDR_W'(row_cnt_q) * ADDR_W'(COLS);
    draw_en  = (state_q == ST_IDLE) && !clear_req && (pen_down || erase);
    wr_val   = ~erase;
    right_ok = (cursor_x_q != 5'(COLS - 1));
    down_ok  = (cursor_y_q != 5'(ROWS - 1));
    pix_d    = pix_q;
    if (state_q == ST_CLEAR) begin
      for (int c = 0; c < COLS; c++) pix_d[row_base + ADDR_W'(c)] = 1'b0;
    end
    if (draw_en) begin
      pix_d[cur_idx] = wr_val;
      if (BRUSH == 2) begin
        if (right_ok)            pix_d[cur_idx + ADDR_W'(1)]        = wr_val;
        if (down_ok)             pix_d[cur_idx + ADDR_W'(COLS)]     = wr_val;
        if (right_ok && down_ok) pix_d[cur_idx + ADDR_W'(COLS + 1)] = wr_val;
      end
    end
  end

  // NOTE: the pixel store is plain flops, so it can and must clear on reset like the control state.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_cnt_q  <= '0;
      cursor_x_q <= 5'(CURSOR_X0);
      cursor_y_q <= 5'(CURSOR_Y0);
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      pix_q      <= pix_d;
    end
  end

  always_comb begin
    read_data = 1'b0;
    if (read_addr < ADDR_W'(NPIX)) read_data = pix_q[read_addr];
  end

  assign cursor_pix = pix_q[cur_idx];
  assign cursor_x   = cursor_x_q;
  assign cursor_y   = cursor_y_q;

endmodule
